// File: rtl/edsac_tank_pkg.sv
// Shared timing constants, FSM state encoding and rack decode helper for the tank distribution unit.
package edsac_tank_pkg;

  localparam int DIGITS_PER_MINOR = 18;
  localparam int MINORS_PER_MAJOR = 32;
  localparam int NUM_RACKS        = 8;

  localparam logic [4:0] DIGIT_LAST = 5'(DIGITS_PER_MINOR - 1);
  localparam logic [4:0] MINOR_LAST = 5'(MINORS_PER_MAJOR - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    ACTIVE,
    DONE
  } tdu_state_e;

  function automatic logic [NUM_RACKS-1:0] rack_onehot(input logic [2:0] rack);
    logic [NUM_RACKS-1:0] v;
    v       = '0;
    v[rack] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tank_timing_counter.sv
// Free-running digit (0..17) / minor-cycle (0..31) position counter; one digit per clock.
module tank_timing_counter
  import edsac_tank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [4:0] o_digit_cnt,
  output logic [4:0] o_minor_cnt,
  output logic       o_digit_last
);

  logic [4:0] r_digit;
  logic [4:0] r_minor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
      r_minor <= '0;
    end else if (r_digit == DIGIT_LAST) begin
      r_digit <= '0;
      r_minor <= (r_minor == MINOR_LAST) ? 5'd0 : r_minor + 5'd1;
    end else begin
      r_digit <= r_digit + 5'd1;
    end
  end

  assign o_digit_cnt  = r_digit;
  assign o_minor_cnt  = r_minor;
  assign o_digit_last = (r_digit == DIGIT_LAST);

endmodule

// File: rtl/tank_distribution_unit.sv
// Opens one rack's tank input/output gate for the minor cycle holding the addressed word.
// Optional feature: define TDU_LONG_WORD_EN for two-minor-cycle long-word windows (acc_addr[0]=1).
module tank_distribution_unit
  import edsac_tank_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       acc_req,
  input  logic       acc_wr,
  input  logic [9:0] acc_addr,
  input  logic       acc_abort,
  output logic       rack_f7_pos,
  output logic       rack_f7_neg,
  output logic       rack_f8_pos,
  output logic       rack_f8_neg,
  output logic [7:0] rack_t_in,
  output logic [7:0] rack_t_out,
  output logic       busy,
  output logic       done,
  output logic [4:0] digit_cnt,
  output logic [4:0] minor_cnt
);

  tdu_state_e r_state;
  tdu_state_e w_state_nxt;

  logic [4:0] r_word;
  logic [4:0] r_last_minor;
  logic [2:0] r_rack;
  logic [1:0] r_tank;
  logic       r_wr;

  logic [4:0] w_digit;
  logic [4:0] w_minor;
  logic [4:0] w_minor_inc;
  logic       w_digit_last;
  logic       w_accept;
  logic       w_slot_next;
  logic       w_window_end;
  logic [4:0] w_tgt_word;
  logic [7:0] w_gate;

  tank_timing_counter u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_digit_cnt  (w_digit),
    .o_minor_cnt  (w_minor),
    .o_digit_last (w_digit_last)
  );

`ifdef TDU_LONG_WORD_EN
  assign w_tgt_word = acc_addr[0] ? {acc_addr[4:1], 1'b0} : acc_addr[4:0];
`else
  assign w_tgt_word = acc_addr[4:0];
`endif

  assign w_accept     = (r_state == IDLE) && acc_req;
  assign w_minor_inc  = w_minor + 5'd1;
  // Enter the window on the edge that moves the counters onto (word, 0).
  assign w_slot_next  = w_digit_last && (w_minor_inc == r_word);
  // The last window minor equals the raw word field in both short and long modes.
  assign w_window_end = w_digit_last && (w_minor == r_last_minor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word       <= '0;
      r_last_minor <= '0;
      r_rack       <= '0;
      r_tank       <= '0;
      r_wr         <= 1'b0;
    end else if (w_accept) begin
      r_word       <= w_tgt_word;
      r_last_minor <= acc_addr[4:0];
      r_rack       <= acc_addr[9:7];
      r_tank       <= acc_addr[6:5];
      r_wr         <= acc_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (acc_req) w_state_nxt = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (acc_abort)        w_state_nxt = IDLE;
        else if (w_slot_next) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (acc_abort)         w_state_nxt = IDLE;
        else if (w_window_end) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Gates decode straight from the state register so an async reset drops them at once.
  assign w_gate      = (r_state == ACTIVE) ? rack_onehot(r_rack) : 8'h00;
  assign rack_t_in   = r_wr ? w_gate : 8'h00;
  assign rack_t_out  = r_wr ? 8'h00 : w_gate;

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign rack_f7_pos = busy & r_tank[0];
  assign rack_f8_pos = busy & r_tank[1];
  assign rack_f7_neg = ~rack_f7_pos;
  assign rack_f8_neg = ~rack_f8_pos;

  assign digit_cnt   = w_digit;
  assign minor_cnt   = w_minor;

endmodule
